// File: rtl/img_mem_arbiter.sv
// Single-port image memory arbiter: VGA pixel reads take strict priority,
// HPS writes are buffered in a small FIFO and drain on VGA-idle cycles.
module img_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hps_chipselect,
  input  logic              hps_write,
  input  logic [3:0]        hps_address,
  input  logic [7:0]        hps_writedata,
  input  logic              vga_rd_req,
  input  logic [ADDR_W-1:0] vga_rd_addr,
  output logic [DATA_W-1:0] vga_rd_data,
  output logic              vga_rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             rd_pend;

  logic hps_wr, push_req, cfg_wr, flush, clr_ovf;
  logic pop, push_ok, drop;

  assign hps_wr   = hps_chipselect & hps_write;
  assign push_req = hps_wr && (hps_address == 4'd2);
  assign cfg_wr   = hps_wr && (hps_address == 4'd3);
  assign flush    = cfg_wr & hps_writedata[0];
  assign clr_ovf  = cfg_wr & hps_writedata[1];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // Gating the pop with reset keeps a buffered entry from being written
  // during the cycle in which reset is being applied.
  assign pop     = !reset && !vga_rd_req && !fifo_empty;
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (vga_rd_req) begin
      mem_addr = vga_rd_addr;
    end else if (pop) begin
      mem_addr = fifo_mem[head][ENT_W-1:DATA_W];
      mem_din  = fifo_mem[head][DATA_W-1:0];
      mem_we   = 1'b1;
    end
  end

  // Entry storage needs no reset: count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      fifo_mem[tail] <= {wr_ptr, DATA_W'(hps_writedata)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      wr_ptr       <= '0;
      overflow     <= 1'b0;
      rd_pend      <= 1'b0;
      vga_rd_valid <= 1'b0;
      vga_rd_data  <= '0;
    end else begin
      rd_pend      <= vga_rd_req;
      vga_rd_valid <= rd_pend;
      if (rd_pend)
        vga_rd_data <= mem_dout;

      if (hps_wr && hps_address == 4'd0)
        wr_ptr[7:0] <= hps_writedata;
      else if (hps_wr && hps_address == 4'd1)
        wr_ptr[15:8] <= hps_writedata;
      else if (push_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);

      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;

      // A flush still lets this cycle's pop write its head entry.
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push_ok)
          tail <= tail + PTR_W'(1);
        if (pop)
          head <= head + PTR_W'(1);
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Directed bench for img_mem_arbiter with a behavioural image memory,
// write/read logs sampled on the falling edge, and an expected write queue.
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        hps_chipselect, hps_write;
  logic [3:0]  hps_address;
  logic [7:0]  hps_writedata;
  logic        vga_rd_req;
  logic [15:0] vga_rd_addr;
  logic [7:0]  vga_rd_data;
  logic        vga_rd_valid;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic [15:0] wr_ptr;
  logic        fifo_empty, fifo_full, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  mem [65536];
  logic [23:0] exp_q[$];
  logic [23:0] wr_log[$];
  int          wr_cyc[$];
  logic [7:0]  rd_log[$];
  int          rd_cyc[$];

  img_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .hps_chipselect(hps_chipselect), .hps_write(hps_write),
    .hps_address(hps_address), .hps_writedata(hps_writedata),
    .vga_rd_req(vga_rd_req), .vga_rd_addr(vga_rd_addr),
    .vga_rd_data(vga_rd_data), .vga_rd_valid(vga_rd_valid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .wr_ptr(wr_ptr), .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) begin
      wr_log.push_back({mem_addr, mem_din});
      wr_cyc.push_back(cyc);
    end
    if (vga_rd_valid) begin
      rd_log.push_back(vga_rd_data);
      rd_cyc.push_back(cyc);
    end
  end

  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ 8'h5C;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle_drive(input logic rq, input logic [15:0] ra, input logic wr,
                             input logic [3:0] a, input logic [7:0] d);
    vga_rd_req     = rq;
    vga_rd_addr    = ra;
    hps_chipselect = wr;
    hps_write      = wr;
    hps_address    = a;
    hps_writedata  = d;
    @(posedge clk); #1;
    vga_rd_req     = 1'b0;
    hps_chipselect = 1'b0;
    hps_write      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    exp_q.delete(); wr_log.delete(); wr_cyc.delete(); rd_log.delete(); rd_cyc.delete();
  endtask

  task automatic compare_writes(input string name);
    n_checks++;
    if (wr_log.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write count: got %0d expected %0d", name, wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= wr_log.size() || wr_log[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s write[%0d]: got %06h expected %06h", name, i,
                 (i < wr_log.size()) ? wr_log[i] : 24'hxxxxxx, exp_q[i]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; vga_rd_req = 0; vga_rd_addr = 0;
    hps_chipselect = 0; hps_write = 0; hps_address = 0; hps_writedata = 0;
    idle(3);
    n_checks++;
    if ({vga_rd_valid, vga_rd_data, wr_ptr, overflow, fifo_empty, fifo_full, mem_we} !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h ptr=%h ovf=%b empty=%b full=%b we=%b expected 0,00,0000,0,1,0,0",
               vga_rd_valid, vga_rd_data, wr_ptr, overflow, fifo_empty, fifo_full, mem_we);
    end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic_write();
    clear_logs();
    cycle_drive(0, 0, 1, 4'd0, 8'h10);
    cycle_drive(0, 0, 1, 4'd1, 8'h00);
    cycle_drive(0, 0, 1, 4'd2, 8'hAA);
    cycle_drive(0, 0, 1, 4'd2, 8'hBB);
    idle(3);
    exp_q.push_back({16'h0010, 8'hAA});
    exp_q.push_back({16'h0011, 8'hBB});
    compare_writes("basic");
    n_checks++;
    if (wr_ptr !== 16'h0012) begin n_fail++; $display("FAIL basic wr_ptr: got %h expected 0012", wr_ptr); end
    n_checks++;
    if ({fifo_empty, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL basic idle: empty=%b we=%b addr=%h expected 1,0,0000", fifo_empty, mem_we, mem_addr);
    end
  endtask

  int burst_start;
  task automatic test_read_priority();
    clear_logs();
    burst_start = cyc;
    for (int i = 0; i < 10; i++)
      cycle_drive(1, 16'h0100 + 16'(i), (i < 6), 4'd2, 8'h30 + 8'(i));
    n_checks++;
    if (wr_log.size() !== 0) begin n_fail++; $display("FAIL starve: got %0d writes expected 0", wr_log.size()); end
    n_checks++;
    if ({overflow, fifo_full} !== 2'b11) begin n_fail++; $display("FAIL burst ovf/full: got %b%b expected 11", overflow, fifo_full); end
    n_checks++;
    if (wr_ptr !== 16'h0016) begin n_fail++; $display("FAIL burst wr_ptr: got %h expected 0016", wr_ptr); end
    idle(2);
    n_checks++;
    if (rd_log.size() !== 10) begin n_fail++; $display("FAIL read count: got %0d expected 10", rd_log.size()); end
    n_checks++;
    if (rd_cyc.size() == 0 || rd_cyc[0] !== burst_start + 2) begin
      n_fail++;
      $display("FAIL read latency: got cycle %0d expected %0d", (rd_cyc.size() > 0) ? rd_cyc[0] : -1, burst_start + 2);
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (i >= rd_log.size() || rd_log[i] !== pattern(16'h0100 + 16'(i)) || rd_cyc[i] !== burst_start + 2 + i) begin
        n_fail++;
        $display("FAIL read[%0d]: got %h expected %h", i, (i < rd_log.size()) ? rd_log[i] : 8'hxx, pattern(16'h0100 + 16'(i)));
      end
    end
  endtask

  task automatic test_drain();
    idle(3);
    for (int i = 0; i < 4; i++) exp_q.push_back({16'h0012 + 16'(i), 8'h30 + 8'(i)});
    compare_writes("drain");
    n_checks++;
    if (wr_cyc.size() != 4 || wr_cyc[3] !== wr_cyc[0] + 3) begin
      n_fail++; $display("FAIL drain consecutive: got %0d writes expected 4 in 4 cycles", wr_cyc.size());
    end
    cycle_drive(0, 0, 1, 4'd3, 8'h02);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL clear_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_push_pop_full();
    clear_logs();
    for (int i = 0; i < 4; i++) cycle_drive(1, 16'h0100, 1, 4'd2, 8'h40 + 8'(i));
    n_checks++;
    if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill: full=%b expected 1", fifo_full); end
    cycle_drive(0, 0, 1, 4'd2, 8'h44);
    n_checks++;
    if ({fifo_full, overflow, wr_ptr} !== {1'b1, 1'b0, 16'h001B}) begin
      n_fail++;
      $display("FAIL push_pop_full: full=%b ovf=%b ptr=%h expected 1,0,001b", fifo_full, overflow, wr_ptr);
    end
    idle(6);
    for (int i = 0; i < 5; i++) exp_q.push_back({16'h0016 + 16'(i), 8'h40 + 8'(i)});
    compare_writes("push_pop_full");
  endtask

  task automatic test_flush();
    clear_logs();
    for (int i = 0; i < 3; i++) cycle_drive(1, 16'h0100, 1, 4'd2, 8'h50 + 8'(i));
    n_checks++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL flush pre: empty=%b expected 0", fifo_empty); end
    cycle_drive(1, 16'h0101, 1, 4'd3, 8'h01);
    n_checks++;
    if ({fifo_empty, wr_ptr} !== {1'b1, 16'h001E}) begin
      n_fail++; $display("FAIL flush: empty=%b ptr=%h expected 1,001e", fifo_empty, wr_ptr);
    end
    idle(4);
    compare_writes("flush");
    // Flush coinciding with a pop: the head is still written.
    clear_logs();
    cycle_drive(1, 16'h0100, 1, 4'd2, 8'h60);
    cycle_drive(1, 16'h0100, 1, 4'd2, 8'h61);
    cycle_drive(0, 0, 1, 4'd3, 8'h01);
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL flush_pop: empty=%b expected 1", fifo_empty); end
    idle(3);
    exp_q.push_back({16'h001E, 8'h60});
    compare_writes("flush_pop");
  endtask

  task automatic test_wrap_and_reset();
    clear_logs();
    cycle_drive(0, 0, 1, 4'd0, 8'hFF);
    cycle_drive(0, 0, 1, 4'd1, 8'hFF);
    n_checks++;
    if (wr_ptr !== 16'hFFFF) begin n_fail++; $display("FAIL ptr_load: got %h expected ffff", wr_ptr); end
    cycle_drive(0, 0, 1, 4'd2, 8'h5A);
    n_checks++;
    if (wr_ptr !== 16'h0000) begin n_fail++; $display("FAIL ptr_wrap: got %h expected 0000", wr_ptr); end
    idle(2);
    exp_q.push_back({16'hFFFF, 8'h5A});
    compare_writes("wrap");

    cycle_drive(0, 0, 1, 4'd0, 8'h34);
    for (int i = 0; i < 5; i++) cycle_drive(1, 16'h0100 + 16'(i), 1, 4'd2, 8'h70 + 8'(i));
    n_checks++;
    if ({overflow, fifo_full, wr_ptr} !== {1'b1, 1'b1, 16'h0038}) begin
      n_fail++; $display("FAIL pre_reset: ovf=%b full=%b ptr=%h expected 1,1,0038", overflow, fifo_full, wr_ptr);
    end
    clear_logs();
    reset = 1'b1;
    @(posedge clk); #1;
    rd_log.delete();
    n_checks++;
    if ({vga_rd_valid, vga_rd_data, wr_ptr, overflow, fifo_empty, fifo_full, mem_we} !== {1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h ptr=%h ovf=%b empty=%b full=%b we=%b expected 0,00,0000,0,1,0,0",
               vga_rd_valid, vga_rd_data, wr_ptr, overflow, fifo_empty, fifo_full, mem_we);
    end
    reset = 1'b0;
    idle(4);
    n_checks++;
    if (rd_log.size() !== 0) begin n_fail++; $display("FAIL reset_discard: got %0d valid pulses expected 0", rd_log.size()); end
    compare_writes("reset_no_write");
  endtask

  initial begin
    for (int a = 16'h0100; a < 16'h0200; a++) mem[a] = pattern(16'(a));
    test_reset();
    test_basic_write();
    test_read_priority();
    test_drain();
    test_push_pop_full();
    test_flush();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
